// File: rtl/hevc_fifo_pkg.sv
// Shared parameters and entry layout for the tagged multi-flux FIFO.
package hevc_fifo_pkg;

    localparam int DEF_FLUX       = 2;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 4;

    // Tag field is at least one bit wide so the entry layout never degenerates.
    function automatic int calcTagWidth(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int calcWidth(input int flux, input int dataWidth);
        return dataWidth + calcTagWidth(flux);
    endfunction

    localparam int DEF_TAG_WIDTH = calcTagWidth(DEF_FLUX);
    localparam int DEF_WIDTH     = calcWidth(DEF_FLUX, DEF_DATA_WIDTH);

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/tagged_fifo_if.sv
// Producer write port and consumer read port of the tagged FIFO.
interface tagged_fifo_if
    import hevc_fifo_pkg::*;
#(
    parameter int FLUX       = DEF_FLUX,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int WIDTH = calcWidth(FLUX, DATA_WIDTH);

    logic             write;
    logic [WIDTH-1:0] din;
    logic             full;
    logic [FLUX-1:0]  read;
    logic [FLUX-1:0]  empty;
    logic [WIDTH-1:0] dout;

    modport write_master (output write, output din, input full);
    modport write_slave  (input write, input din, output full);
    modport read_master  (output read, input empty, input dout);
    modport read_slave   (input read, output empty, output dout);

endinterface

// File: rtl/tagged_fifo_tag_queue.sv
// One circular queue of a single flux: storage, pointers and occupancy count.
module tag_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  doPush;
    logic                  doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        if (doPush && !doPop) count_d = count_q + 1'b1;
        if (doPop && !doPush) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; the empty flag keeps stale slots hidden.
    always_ff @(posedge clk) begin
        if (doPush && !rst) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/tagged_fifo.sv
// Multi-flux FIFO: tag decode into per-flux queues, global full, highest-flux-first output.
module tagged_fifo
    import hevc_fifo_pkg::*;
#(
    parameter int FLUX       = DEF_FLUX,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    tagged_fifo_if.write_slave    write_port,
    tagged_fifo_if.read_slave     read_port
);
    localparam int TAG_WIDTH = calcTagWidth(FLUX);
    localparam int WIDTH     = calcWidth(FLUX, DATA_WIDTH);

    logic [TAG_WIDTH-1:0]  wrTag;
    logic [DATA_WIDTH-1:0] wrData;
    logic [FLUX-1:0]       push;
    logic [FLUX-1:0]       qEmpty;
    logic [FLUX-1:0]       qFull;
    logic [DATA_WIDTH-1:0] headData [FLUX];
    logic                  anyFull;
    logic [TAG_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] selData;
    logic                  found;

    assign wrTag   = write_port.din[WIDTH-1:DATA_WIDTH];
    assign wrData  = write_port.din[DATA_WIDTH-1:0];
    assign anyFull = |qFull;

    assign write_port.full = anyFull;
    assign read_port.empty = qEmpty;

    // A tag of FLUX or above matches no queue and is silently dropped.
    for (genvar gi = 0; gi < FLUX; gi++) begin : gQueue
        assign push[gi] = write_port.write && !anyFull && (wrTag == TAG_WIDTH'(gi));

        tag_queue #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) uQueue (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[gi]),
            .data_i  (wrData),
            .pop_i   (read_port.read[gi]),
            .head_o  (headData[gi]),
            .empty_o (qEmpty[gi]),
            .full_o  (qFull[gi])
        );
    end

    // Ascending scan so the highest non-empty flux wins.
    always_comb begin
        sel     = '0;
        selData = '0;
        found   = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            if (!qEmpty[i]) begin
                sel     = TAG_WIDTH'(i);
                selData = headData[i];
                found   = 1'b1;
            end
        end
        read_port.dout = found ? {sel, selData} : '0;
    end

endmodule

// File: tb/tb_tagged_fifo.sv
// Self-checking bench for tagged_fifo: directed scenarios plus random traffic against a queue model.
module tb_tagged_fifo;
    import hevc_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    logic [15:0] mq0[$];
    logic [15:0] mq1[$];

    tagged_fifo_if #(.FLUX(2), .DATA_WIDTH(16)) ifA ();
    tagged_fifo_if #(.FLUX(3), .DATA_WIDTH(16)) ifB ();

    tagged_fifo #(.FLUX(2), .DATA_WIDTH(16), .DEPTH(DEPTH)) dutA (
        .clk        (clk),
        .rst        (rst),
        .write_port (ifA),
        .read_port  (ifA)
    );

    tagged_fifo #(.FLUX(3), .DATA_WIDTH(16), .DEPTH(DEPTH)) dutB (
        .clk        (clk),
        .rst        (rst),
        .write_port (ifB),
        .read_port  (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic wr, input logic [16:0] din, input logic [1:0] rd);
        bit wasFull;
        wasFull = (mq0.size() == DEPTH) || (mq1.size() == DEPTH);
        if (rd[0] && mq0.size() > 0) void'(mq0.pop_front());
        if (rd[1] && mq1.size() > 0) void'(mq1.pop_front());
        if (wr && !wasFull) begin
            if (din[16]) mq1.push_back(din[15:0]);
            else         mq0.push_back(din[15:0]);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0]  expEmpty;
        logic        expFull;
        logic [16:0] expDout;
        expEmpty = {mq1.size() == 0, mq0.size() == 0};
        expFull  = (mq0.size() == DEPTH) || (mq1.size() == DEPTH);
        if (mq1.size() > 0)      expDout = {1'b1, mq1[0]};
        else if (mq0.size() > 0) expDout = {1'b0, mq0[0]};
        else                     expDout = '0;
        checkValue({tag, "_empty"}, 32'(ifA.empty), 32'(expEmpty));
        checkValue({tag, "_full"},  32'(ifA.full),  32'(expFull));
        checkValue({tag, "_dout"},  32'(ifA.dout),  32'(expDout));
    endtask

    task automatic applyStimulus(input logic wr, input logic [16:0] din, input logic [1:0] rd, input string tag);
        ifA.write = wr;
        ifA.din   = din;
        ifA.read  = rd;
        @(posedge clk);
        #1;
        ifA.write = 1'b0;
        ifA.din   = '0;
        ifA.read  = '0;
        modelStep(wr, din, rd);
        checkOutput(tag);
    endtask

    task automatic applyStimulusB(input logic wr, input logic [17:0] din, input logic [2:0] rd);
        ifB.write = wr;
        ifB.din   = din;
        ifB.read  = rd;
        @(posedge clk);
        #1;
        ifB.write = 1'b0;
        ifB.din   = '0;
        ifB.read  = '0;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        ifA.write = 1'b0;
        ifA.din   = '0;
        ifA.read  = '0;
        ifB.write = 1'b0;
        ifB.din   = '0;
        ifB.read  = '0;

        @(posedge clk);
        #1;
        checkOutput("reset");
        checkValue("resetB_empty", 32'(ifB.empty), 32'h7);
        checkValue("resetB_dout",  32'(ifB.dout),  32'h0);
        rst = 1'b0;

        // Single flux write then pop.
        applyStimulus(1'b1, 17'h10123, 2'b00, "single_wr");
        checkValue("single_empty", 32'(ifA.empty), 32'h1);
        checkValue("single_dout",  32'(ifA.dout),  32'h10123);
        applyStimulus(1'b0, 17'h0, 2'b10, "single_rd");
        checkValue("single_rd_empty", 32'(ifA.empty), 32'h3);

        // Priority between fluxes.
        applyStimulus(1'b1, 17'h000AA, 2'b00, "prio_wr0");
        applyStimulus(1'b1, 17'h100BB, 2'b00, "prio_wr1");
        checkValue("prio_dout1", 32'(ifA.dout), 32'h100BB);
        applyStimulus(1'b0, 17'h0, 2'b10, "prio_pop1");
        checkValue("prio_dout0", 32'(ifA.dout), 32'h000AA);
        applyStimulus(1'b0, 17'h0, 2'b01, "prio_pop0");

        // Fill flux0, overflow attempt, drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 17'(i), 2'b00, "full_wr");
        checkValue("full_set", 32'(ifA.full), 32'h1);
        applyStimulus(1'b1, 17'h00005, 2'b00, "full_overflow");
        checkValue("full_overflow_dout", 32'(ifA.dout), 32'h00001);
        applyStimulus(1'b1, 17'h10009, 2'b00, "full_block_other");
        checkValue("full_block_empty", 32'(ifA.empty), 32'h2);
        applyStimulus(1'b0, 17'h0, 2'b01, "full_pop");
        checkValue("full_clear", 32'(ifA.full), 32'h0);
        checkValue("full_order2", 32'(ifA.dout), 32'h00002);
        applyStimulus(1'b0, 17'h0, 2'b01, "drain3");
        checkValue("full_order3", 32'(ifA.dout), 32'h00003);
        applyStimulus(1'b0, 17'h0, 2'b01, "drain4");
        checkValue("full_order4", 32'(ifA.dout), 32'h00004);
        applyStimulus(1'b0, 17'h0, 2'b01, "drain_end");

        // Continuous write+read on flux1 keeps one entry and wraps the pointers.
        applyStimulus(1'b1, 17'h10100, 2'b00, "wrap_seed");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, {1'b1, 16'(16'h0100 + i)}, 2'b10, "wrap_step");
            checkValue("wrap_dout", 32'(ifA.dout), 32'({1'b1, 16'(16'h0100 + i)}));
        end
        checkValue("wrap_empty", 32'(ifA.empty), 32'h1);

        // Asynchronous reset mid-stream, with traffic presented during reset.
        applyStimulus(1'b1, 17'h00011, 2'b00, "pre_rst_a");
        #3;
        rst = 1'b1;
        #1;
        checkValue("rst_async_empty", 32'(ifA.empty), 32'h3);
        checkValue("rst_async_full",  32'(ifA.full),  32'h0);
        checkValue("rst_async_dout",  32'(ifA.dout),  32'h0);
        mq0.delete();
        mq1.delete();
        ifA.write = 1'b1;
        ifA.din   = 17'h10077;
        ifA.read  = 2'b11;
        @(posedge clk);
        #1;
        ifA.write = 1'b0;
        ifA.din   = '0;
        ifA.read  = '0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst");
        applyStimulus(1'b1, 17'h00042, 2'b00, "resume");

        // Illegal tag on the three-flux instance.
        applyStimulusB(1'b1, 18'h10055, 3'b000);
        checkValue("illegal_pre_empty", 32'(ifB.empty), 32'h5);
        applyStimulusB(1'b1, 18'h30099, 3'b000);
        checkValue("illegal_empty", 32'(ifB.empty), 32'h5);
        checkValue("illegal_dout",  32'(ifB.dout),  32'h10055);
        checkValue("illegal_full",  32'(ifB.full),  32'h0);
        applyStimulusB(1'b1, 18'h20066, 3'b000);
        checkValue("flux2_dout", 32'(ifB.dout), 32'h20066);
        applyStimulusB(1'b0, 18'h0, 3'b110);
        checkValue("flux2_drain_empty", 32'(ifB.empty), 32'h7);

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            logic        wr;
            logic [16:0] din;
            logic [1:0]  rd;
            wr  = ($urandom_range(0, 3) != 0);
            din = 17'($urandom());
            rd  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            applyStimulus(wr, din, rd, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
